// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing (counters, syncs, blank, strobes, frame counter).
// Latency: DrawX/DrawY and every registered output are mutually aligned; next_* lead them by one cycle.
// Backpressure: none, free-running from vga_clk.
// Ports: vga_clk/reset in; hs/vs sync out; blank (1 = visible); DrawX/DrawY current position;
//        next_x/next_y/next_blank one-pixel-ahead view; line_start/frame_start pulses; frame_count.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        vga_clk,
   input  logic        reset,
   output logic        hs,
   output logic        vs,
   output logic        blank,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic [9:0]  next_x,
   output logic [9:0]  next_y,
   output logic        next_blank,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [9:0] hc;
   logic [9:0] vc;
   logic [9:0] nx;
   logic [9:0] ny;
   logic       nb;
   logic       hs_nxt;
   logic       vs_nxt;
   logic       at_line_start;
   logic       at_frame_start;

   // Position the counters will hold after the next edge.
   always_comb begin
      nx = hc + 10'd1;
      ny = vc;
      if (hc == H_LAST) begin
         nx = '0;
         ny = (vc == V_LAST) ? '0 : vc + 10'd1;
      end
   end

   // All registered outputs are decoded from the next position so they
   // land in the same cycle as the coordinates they describe.
   always_comb begin
      nb             = (nx < H_VIS) && (ny < V_VIS);
      hs_nxt         = ((nx >= HS_FIRST) && (nx <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vs_nxt         = ((ny >= VS_FIRST) && (ny <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      at_line_start  = (nx == '0);
      at_frame_start = (nx == '0) && (ny == '0);
   end

   // Reset parks the raster at (0,0) with strobes low, so the first
   // post-reset cycle is pixel (0,0) without a start pulse.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         hc          <= '0;
         vc          <= '0;
         hs          <= ~SYNC_POL;
         vs          <= ~SYNC_POL;
         blank       <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else begin
         hc          <= nx;
         vc          <= ny;
         hs          <= hs_nxt;
         vs          <= vs_nxt;
         blank       <= nb;
         line_start  <= at_line_start;
         frame_start <= at_frame_start;
         if (at_frame_start) begin
            frame_count <= frame_count + 16'd1;
         end
      end
   end

   assign DrawX      = hc;
   assign DrawY      = vc;
   assign next_x     = nx;
   assign next_y     = ny;
   assign next_blank = nb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks vga_timing_gen against a cycle-count model of the raster.
// Two instances share clock and reset: standard 640x480 timing, and a shrunken
// active-high-sync variant that lets whole frames, wraps and frame counting run quickly.
module tb_vga_timing_gen;

   // shrunken timing: 30 x 15, frame = 450 cycles
   localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 4;
   localparam int SVA = 8,  SVF = 2, SVS = 2, SVB = 3;
   localparam int S_FRAME = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

   logic vga_clk = 1'b0;
   logic reset   = 1'b1;

   logic        s_hs, s_vs, s_blank, s_nb, s_ls, s_fs;
   logic [9:0]  s_dx, s_dy, s_nx, s_ny;
   logic [15:0] s_fc;
   logic        d_hs, d_vs, d_blank, d_nb, d_ls, d_fs;
   logic [9:0]  d_dx, d_dy, d_nx, d_ny;
   logic [15:0] d_fc;

   int    n_chk  = 0;
   int    n_fail = 0;
   longint t     = 0;   // edges taken since reset release

   always #20 vga_clk = ~vga_clk;

   vga_timing_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
      .SYNC_POL(1'b1)
   ) dut_small (
      .vga_clk(vga_clk), .reset(reset),
      .hs(s_hs), .vs(s_vs), .blank(s_blank),
      .DrawX(s_dx), .DrawY(s_dy), .next_x(s_nx), .next_y(s_ny), .next_blank(s_nb),
      .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
   );

   vga_timing_gen dut_std (
      .vga_clk(vga_clk), .reset(reset),
      .hs(d_hs), .vs(d_vs), .blank(d_blank),
      .DrawX(d_dx), .DrawY(d_dy), .next_x(d_nx), .next_y(d_ny), .next_blank(d_nb),
      .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got=%0d expected=%0d", tag, t, got, exp);
      end
   endtask

   // Reference: the raster position is simply elapsed cycles modulo the line
   // and frame lengths; every output is a range test on that position.
   task automatic check_inst(
      input string nm,
      input int ha, input int hf, input int hsw, input int hb,
      input int va, input int vf, input int vsw, input int vb,
      input bit pol,
      input logic o_hs, input logic o_vs, input logic o_blank,
      input logic [9:0] o_dx, input logic [9:0] o_dy,
      input logic [9:0] o_nx, input logic [9:0] o_ny, input logic o_nb,
      input logic o_ls, input logic o_fs, input logic [15:0] o_fc);
      longint ht, vt, x, y, xn, yn;
      bit e_hs, e_vs;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      x  = t % ht;
      y  = (t / ht) % vt;
      xn = (t + 1) % ht;
      yn = ((t + 1) / ht) % vt;
      e_hs = (x >= ha + hf && x < ha + hf + hsw) ? pol : !pol;
      e_vs = (y >= va + vf && y < va + vf + vsw) ? pol : !pol;
      chk({nm, ".DrawX"},       32'(o_dx), 32'(x));
      chk({nm, ".DrawY"},       32'(o_dy), 32'(y));
      chk({nm, ".next_x"},      32'(o_nx), 32'(xn));
      chk({nm, ".next_y"},      32'(o_ny), 32'(yn));
      chk({nm, ".blank"},       32'(o_blank), 32'(x < ha && y < va));
      chk({nm, ".next_blank"},  32'(o_nb), 32'(xn < ha && yn < va));
      chk({nm, ".hs"},          32'(o_hs), 32'(e_hs));
      chk({nm, ".vs"},          32'(o_vs), 32'(e_vs));
      chk({nm, ".line_start"},  32'(o_ls), 32'(t > 0 && x == 0));
      chk({nm, ".frame_start"}, 32'(o_fs), 32'(t > 0 && x == 0 && y == 0));
      chk({nm, ".frame_count"}, 32'(o_fc), 32'((t / (ht * vt)) % 65536));
   endtask

   task automatic check_all();
      check_inst("small", SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1,
                 s_hs, s_vs, s_blank, s_dx, s_dy, s_nx, s_ny, s_nb, s_ls, s_fs, s_fc);
      check_inst("std", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                 d_hs, d_vs, d_blank, d_dx, d_dy, d_nx, d_ny, d_nb, d_ls, d_fs, d_fc);
   endtask

   // One clock: account for the edge just taken, apply the new reset level
   // just after it, then compare everything at the falling edge.
   task automatic step(input logic r);
      @(posedge vga_clk);
      if (!reset) t++;
      #1;
      reset = r;
      if (r) t = 0;
      @(negedge vga_clk);
      check_all();
   endtask

   int ls_cnt, fs_cnt, hs_low_cnt;

   initial begin
      // reset held 5 cycles
      for (int i = 0; i < 5; i++) step(1'b1);

      // three small frames, tallying strobes; standard instance covers its first lines
      ls_cnt = 0; fs_cnt = 0; hs_low_cnt = 0;
      step(1'b0);
      if (d_hs == 1'b0) hs_low_cnt++;
      while (t < 3 * S_FRAME + 2) begin
         step(1'b0);
         if (t <= 3 * S_FRAME) begin
            ls_cnt += int'(s_ls);
            fs_cnt += int'(s_fs);
         end
         if (t < 800 && d_hs == 1'b0) hs_low_cnt++;
      end
      chk("small.line_pulses", 32'(ls_cnt), 32'(3 * (SVA + SVF + SVS + SVB)));
      chk("small.frame_pulses", 32'(fs_cnt), 32'd3);
      chk("std.hs_low_in_line0", 32'(hs_low_cnt), 32'd96);

      // mid-frame reset at small position (12,9)
      step(1'b1);
      step(1'b0);
      while (t < 9 * (SHA + SHF + SHS + SHB) + 12) step(1'b0);
      for (int i = 0; i < 3; i++) step(1'b1);
      for (int i = 0; i < 40; i++) step(1'b0);

      // random run lengths and reset pulses
      for (int e = 0; e < 6; e++) begin
         int run_len, rst_len;
         run_len = int'($urandom_range(1, 2 * S_FRAME));
         rst_len = int'($urandom_range(1, 4));
         for (int i = 0; i < run_len; i++) step(1'b0);
         for (int i = 0; i < rst_len; i++) step(1'b1);
      end
      for (int i = 0; i < S_FRAME + 5; i++) step(1'b0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
